// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-instruction program sequencer sitting between the ALU
// core and the AXI master request/response adapter.
//
// Each instruction is fetched from data memory, then its operands are read
// (from memory, or src2 taken from the imm8 field), one ALU pass is made and
// the result is written back.
//
// Instruction word:
//   [31:28] opcode  [27] imm  [23:16] src1  [15:8] src2/imm8  [7:0] dst
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   start, abort           begin a program / stop at the next instruction boundary
//   start_pc, prog_len     first instruction byte offset, instruction count (0 = until HALT)
//   busy, done, error      status; done is a one-cycle pulse, error is sticky
//   pc, instr_count, flags current offset, retired count, {carry, zero}
//   alu_*                  operands to and results from the combinational ALU
//   read_* / write_*       memory request/response handshake
module cpu_sequencer #(
    parameter int unsigned            ADDR_WIDTH    = 32,
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0]  MEM_BASE_ADDR = 32'h8000_0000,
    parameter int unsigned            CNT_WIDTH     = 8,
    parameter logic [3:0]             HALT_OPCODE   = 4'hF
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic [CNT_WIDTH-1:0]  prog_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [CNT_WIDTH-1:0]  instr_count,
    output logic [1:0]            flags,
    output logic [3:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_operand_a,
    output logic [DATA_WIDTH-1:0] alu_operand_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero_flag,
    input  logic                  alu_carry_flag,
    output logic                  read_req,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_done,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_err,
    output logic                  write_req,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_done,
    input  logic                  write_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OP1, S_OP2, S_EXEC, S_STORE, S_NEXT, S_ERR
    } state_t;

    localparam logic [3:0]            OPC_NOT = 4'h5;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [31:0]           ir_q;
    logic [3:0]            opcode_q;
    logic                  imm_q;
    logic [7:0]            src1_q;
    logic [7:0]            src2_q;
    logic [7:0]            dst_q;
    logic [DATA_WIDTH-1:0] opa_q;
    logic [DATA_WIDTH-1:0] opb_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [1:0]            flags_q;
    logic                  error_q;
    logic                  abort_q;
    logic                  done_q;

    logic [ADDR_WIDTH-1:0] pc_d;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic                  last_d;
    logic                  busy_w;
    logic                  unused_ir;

    function automatic logic [ADDR_WIDTH-1:0] mem_addr(input logic [7:0] field);
        return MEM_BASE_ADDR | ADDR_WIDTH'(field);
    endfunction

    assign pc_d      = pc_q + PC_STEP;
    assign cnt_d     = cnt_q + CNT_WIDTH'(1);
    assign last_d    = (len_q != '0) && (cnt_d == len_q);
    assign busy_w    = (state_q != S_IDLE) && (state_q != S_ERR);
    // Bits [26:24] are reserved in the instruction word.
    assign unused_ir = ^ir_q[26:24];

    // Request outputs decode the state register only, so an asynchronous
    // reset drops them immediately and address/data stay stable while waiting.
    always_comb begin
        read_req   = 1'b0;
        read_addr  = '0;
        write_req  = 1'b0;
        write_addr = '0;
        write_data = '0;
        case (state_q)
            S_FETCH: begin
                read_req  = 1'b1;
                read_addr = MEM_BASE_ADDR | pc_q;
            end
            S_OP1: begin
                read_req  = 1'b1;
                read_addr = mem_addr(src1_q);
            end
            S_OP2: begin
                read_req  = 1'b1;
                read_addr = mem_addr(src2_q);
            end
            S_STORE: begin
                write_req  = 1'b1;
                write_addr = mem_addr(dst_q);
                write_data = result_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            ir_q     <= '0;
            opcode_q <= '0;
            imm_q    <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            error_q  <= 1'b0;
            abort_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort only takes effect in NEXT, so the running instruction retires.
            if (busy_w && abort) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= start_pc;
                        cnt_q   <= '0;
                        len_q   <= prog_len;
                        error_q <= 1'b0;
                        abort_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (read_done) begin
                        if (read_err) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            ir_q    <= read_data[31:0];
                            state_q <= S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (ir_q[31:28] == HALT_OPCODE) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        opcode_q <= ir_q[31:28];
                        imm_q    <= ir_q[27];
                        src1_q   <= ir_q[23:16];
                        src2_q   <= ir_q[15:8];
                        dst_q    <= ir_q[7:0];
                        if (ir_q[27]) begin
                            opb_q <= DATA_WIDTH'(ir_q[15:8]);
                        end
                        state_q <= S_OP1;
                    end
                end
                S_OP1: begin
                    if (read_done) begin
                        if (read_err) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            opa_q   <= read_data;
                            state_q <= (imm_q || (opcode_q == OPC_NOT)) ? S_EXEC : S_OP2;
                        end
                    end
                end
                S_OP2: begin
                    if (read_done) begin
                        if (read_err) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            opb_q   <= read_data;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    result_q <= alu_result;
                    flags_q  <= {alu_carry_flag, alu_zero_flag};
                    state_q  <= S_STORE;
                end
                S_STORE: begin
                    if (write_done) begin
                        if (write_err) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    cnt_q <= cnt_d;
                    pc_q  <= pc_d;
                    if (abort_q || last_d) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_w;
    assign done          = done_q;
    assign error         = error_q;
    assign pc            = pc_q;
    assign instr_count   = cnt_q;
    assign flags         = flags_q;
    assign alu_opcode    = opcode_q;
    assign alu_operand_a = opa_q;
    assign alu_operand_b = opb_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a small ALU model, a byte-offset
// indexed memory with configurable read/write wait states and read-error
// injection, a table of single-instruction programs, and directed sequences
// for HALT, abort, bus error, mid-transaction reset and wait states.
module tb_cpu_sequencer;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          start;
    logic          abort;
    logic [AW-1:0] start_pc;
    logic [CW-1:0] prog_len;
    logic          busy, done, error;
    logic [AW-1:0] pc;
    logic [CW-1:0] instr_count;
    logic [1:0]    flags;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_operand_a, alu_operand_b, alu_result;
    logic          alu_zero_flag, alu_carry_flag;
    logic          read_req, read_done, read_err;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic          write_req, write_done, write_err;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;

    always #5 ACLK = ~ACLK;

    cpu_sequencer #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_BASE_ADDR(32'h8000_0000),
        .CNT_WIDTH    (CW),
        .HALT_OPCODE  (4'hF)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .abort         (abort),
        .start_pc      (start_pc),
        .prog_len      (prog_len),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .pc            (pc),
        .instr_count   (instr_count),
        .flags         (flags),
        .alu_opcode    (alu_opcode),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_result    (alu_result),
        .alu_zero_flag (alu_zero_flag),
        .alu_carry_flag(alu_carry_flag),
        .read_req      (read_req),
        .read_addr     (read_addr),
        .read_done     (read_done),
        .read_data     (read_data),
        .read_err      (read_err),
        .write_req     (write_req),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_done    (write_done),
        .write_err     (write_err)
    );

    // ALU: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR, 5 NOT, else pass A
    logic [DW:0] alu_s;
    always_comb begin
        alu_s = '0;
        case (alu_opcode)
            4'h0:    alu_s = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
            4'h1:    alu_s = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
            4'h2:    alu_s = {1'b0, alu_operand_a & alu_operand_b};
            4'h3:    alu_s = {1'b0, alu_operand_a | alu_operand_b};
            4'h4:    alu_s = {1'b0, alu_operand_a ^ alu_operand_b};
            4'h5:    alu_s = {1'b0, ~alu_operand_a};
            default: alu_s = {1'b0, alu_operand_a};
        endcase
        alu_result     = alu_s[DW-1:0];
        alu_carry_flag = alu_s[DW];
        alu_zero_flag  = (alu_s[DW-1:0] == '0);
    end

    // Memory model
    logic [DW-1:0] mem [0:255];
    int rd_wait = 0, wr_wait = 0;
    int rd_wcnt = 0, wr_wcnt = 0;
    int rd_total = 0, wr_total = 0, done_total = 0;
    int err_read_idx = -1;
    logic [AW-1:0] wr_addr_log [0:255];
    logic [DW-1:0] wr_data_log [0:255];

    assign read_done  = read_req && (rd_wcnt >= rd_wait);
    assign read_data  = read_req ? mem[read_addr[7:0]] : '0;
    assign read_err   = read_done && (rd_total == err_read_idx);
    assign write_done = write_req && (wr_wcnt >= wr_wait);
    assign write_err  = 1'b0;

    // Stability monitor state
    logic          p_rreq = 1'b0, p_rdone = 1'b0, p_wreq = 1'b0, p_wdone = 1'b0;
    logic [AW-1:0] p_raddr = '0, p_waddr = '0;
    logic [DW-1:0] p_wdata = '0;
    int            stab_viol = 0;

    always @(posedge ACLK) begin
        if (!read_req || read_done) rd_wcnt <= 0; else rd_wcnt <= rd_wcnt + 1;
        if (!write_req || write_done) wr_wcnt <= 0; else wr_wcnt <= wr_wcnt + 1;
        if (read_done) rd_total <= rd_total + 1;
        if (write_done && !write_err) begin
            wr_addr_log[wr_total % 256] <= write_addr;
            wr_data_log[wr_total % 256] <= write_data;
            wr_total <= wr_total + 1;
        end
        if (done) done_total <= done_total + 1;
        if ((read_req && p_rreq && !p_rdone && read_addr != p_raddr) ||
            (write_req && p_wreq && !p_wdone && (write_addr != p_waddr || write_data != p_wdata)))
            stab_viol <= stab_viol + 1;
        p_rreq  <= read_req;
        p_rdone <= read_done;
        p_raddr <= read_addr;
        p_wreq  <= write_req;
        p_wdone <= write_done;
        p_waddr <= write_addr;
        p_wdata <= write_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_prog(input logic [AW-1:0] spc, input logic [CW-1:0] plen,
                            output int lat, output logic d_end, output logic d_after,
                            output logic busy_st, output logic err_st);
        @(negedge ACLK);
        start_pc = spc;
        prog_len = plen;
        start    = 1'b1;
        @(posedge ACLK);
        #1;
        start   = 1'b0;
        busy_st = busy;
        err_st  = error;
        lat     = 0;
        while (busy && lat < 400) begin
            @(posedge ACLK);
            #1;
            lat++;
        end
        chk("run_timeout", {63'd0, busy}, 64'd0);
        d_end = done;
        @(posedge ACLK);
        #1;
        d_after = done;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  flg;
        int          reads;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, rb, wb, db, n;
        logic d0, d1, bs, es;

        vecs[0] = '{32'h0010_1420, 32'd5,         32'd7, 32'h8000_0020, 32'd12,        2'b00, 3, 7};
        vecs[1] = '{32'h0810_0920, 32'd3,         32'd0, 32'h8000_0020, 32'h0000_000C, 2'b00, 2, 6};
        vecs[2] = '{32'h1010_1424, 32'd5,         32'd5, 32'h8000_0024, 32'd0,         2'b01, 3, 7};
        vecs[3] = '{32'h0010_1428, 32'hFFFF_FFFF, 32'd1, 32'h8000_0028, 32'd0,         2'b11, 3, 7};
        vecs[4] = '{32'h5010_002C, 32'h0F0F_0F0F, 32'd9, 32'h8000_002C, 32'hF0F0_F0F0, 2'b00, 2, 6};
        vecs[5] = '{32'h4810_FF30, 32'h0000_00F0, 32'd0, 32'h8000_0030, 32'h0000_000F, 2'b00, 2, 6};
        vecs[6] = '{32'h1010_1434, 32'd3,         32'd5, 32'h8000_0034, 32'hFFFF_FFFE, 2'b10, 3, 7};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        ARESETN  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        start_pc = '0;
        prog_len = '0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_ctrl", {55'd0, busy, done, error, flags, read_req, write_req, instr_count == 0}, 64'd1);
        chk("rst_pc", pc, 0);
        chk("rst_alu", {alu_opcode, alu_operand_a | alu_operand_b}, 0);
        chk("rst_addr", read_addr | write_addr | write_data, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Single-instruction programs
        for (int i = 0; i < 7; i++) begin
            mem[8'h00] = vecs[i].instr;
            mem[8'h10] = vecs[i].a;
            mem[8'h14] = vecs[i].b;
            rb = rd_total;
            wb = wr_total;
            run_prog(32'h0, 8'd1, lat, d0, d1, bs, es);
            chk($sformatf("v%0d_busy_next", i), {63'd0, bs}, 64'd1);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_done", i), {d0, d1}, 2'b10);
            chk($sformatf("v%0d_writes", i), wr_total - wb, 1);
            chk($sformatf("v%0d_reads", i), rd_total - rb, vecs[i].reads);
            chk($sformatf("v%0d_waddr", i), wr_addr_log[wb % 256], vecs[i].waddr);
            chk($sformatf("v%0d_wdata", i), wr_data_log[wb % 256], vecs[i].wdata);
            chk($sformatf("v%0d_flags", i), flags, vecs[i].flg);
            chk($sformatf("v%0d_cnt_pc", i), {instr_count, pc}, {8'd1, 32'h4});
        end

        // Three instructions then HALT, prog_len = 0
        mem[8'h00] = 32'h0010_1440;
        mem[8'h04] = 32'h0818_0544;
        mem[8'h08] = 32'h501C_0048;
        mem[8'h0C] = 32'hF000_0000;
        mem[8'h10] = 32'd1;
        mem[8'h14] = 32'd2;
        mem[8'h18] = 32'd3;
        mem[8'h1C] = 32'd8;
        rb = rd_total; wb = wr_total; db = done_total;
        run_prog(32'h0, 8'd0, lat, d0, d1, bs, es);
        chk("halt_latency", lat, 21);
        chk("halt_done_once", done_total - db, 1);
        chk("halt_writes", wr_total - wb, 3);
        chk("halt_reads", rd_total - rb, 8);
        chk("halt_cnt_pc", {instr_count, pc}, {8'd3, 32'hC});
        chk("halt_w0", {wr_addr_log[wb % 256], wr_data_log[wb % 256]}, {32'h8000_0040, 32'd3});
        chk("halt_w1", {wr_addr_log[(wb + 1) % 256], wr_data_log[(wb + 1) % 256]}, {32'h8000_0044, 32'd8});
        chk("halt_w2", {wr_addr_log[(wb + 2) % 256], wr_data_log[(wb + 2) % 256]}, {32'h8000_0048, 32'hFFFF_FFF7});

        // Abort during OP1 of instruction 2 of 5; a start pulse at the same time is ignored
        for (int k = 0; k < 5; k++) mem[8'h80 + 4 * k] = 32'h0010_1450 + 32'(4 * k);
        mem[8'h10] = 32'd5;
        mem[8'h14] = 32'd7;
        rb = rd_total; wb = wr_total; db = done_total;
        @(negedge ACLK);
        start_pc = 32'h80;
        prog_len = 8'd5;
        start    = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        n = 0;
        while (!(read_req && rd_total == rb + 4) && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("abort_sync_addr", read_addr, 32'h8000_0010);
        abort    = 1'b1;
        start    = 1'b1;
        start_pc = 32'h40;
        @(negedge ACLK);
        abort = 1'b0;
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        chk("abort_idle_done", {busy, done}, 2'b01);
        chk("abort_cnt_pc", {instr_count, pc}, {8'd2, 32'h88});
        chk("abort_writes", wr_total - wb, 2);
        chk("abort_w1", {wr_addr_log[(wb + 1) % 256], wr_data_log[(wb + 1) % 256]}, {32'h8000_0054, 32'd12});
        @(posedge ACLK);
        #1;
        chk("abort_done_once", done_total - db, 1);

        // Read error on OP2, then a clean restart
        mem[8'h00] = 32'h0010_1420;
        rb = rd_total; wb = wr_total; db = done_total;
        err_read_idx = rd_total + 2;
        run_prog(32'h0, 8'd1, lat, d0, d1, bs, es);
        chk("rderr_latency", lat, 4);
        chk("rderr_status", {busy, error, d0, d1}, 4'b0100);
        chk("rderr_no_write", wr_total - wb, 0);
        chk("rderr_no_done", done_total - db, 0);
        err_read_idx = -1;
        wb = wr_total;
        run_prog(32'h0, 8'd1, lat, d0, d1, bs, es);
        chk("rderr_clear", {bs, es}, 2'b10);
        chk("rderr_rerun", {error, d0, lat[3:0]}, {1'b0, 1'b1, 4'd7});
        chk("rderr_rerun_w", wr_data_log[wb % 256], 32'd12);

        // Reset asserted while write_req is high
        wr_wait = 5;
        @(negedge ACLK);
        start_pc = 32'h0;
        prog_len = 8'd1;
        start    = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        n = 0;
        while (!write_req && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("mid_wreq_seen", {63'd0, write_req}, 64'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_ctrl", {busy, done, error, read_req, write_req, flags}, 7'd0);
        chk("mid_rst_regs", {instr_count, pc, alu_opcode}, 0);
        chk("mid_rst_bus", write_addr | write_data | read_addr | alu_operand_a | alu_operand_b, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        wr_wait = 0;
        rd_wait = 3;
        wb = wr_total;
        run_prog(32'h0, 8'd1, lat, d0, d1, bs, es);
        chk("wait_latency", lat, 16);
        chk("wait_result", {d0, wr_addr_log[wb % 256], wr_data_log[wb % 256]}, {1'b1, 32'h8000_0020, 32'd12});
        rd_wait = 0;

        chk("addr_stable", stab_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
